// File: rtl/wb_uart_tx_if.sv
// Write-back tap from pu into the UART transmitter: write strobe and data in,
// serial line and status out. Plain clk/rst stay outside the interface.
interface wb_uart_tx_if #(
  parameter int DW    = 16,
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          we;
  logic [DW-1:0] rwd;
  logic          txd;
  logic          busy;
  logic          ovf;
  logic [LW-1:0] level;

  modport master (
    output we, rwd,
    input  txd, busy, ovf, level
  );

  modport slave (
    input  we, rwd,
    output txd, busy, ovf, level
  );
endinterface

// File: rtl/wb_uart_tx.sv
// Buffers pu write-back words in a small FIFO and serialises each one as
// ceil(DW/8) 8N1 bytes, least-significant byte first. Never stalls pu.
module wb_uart_tx #(
  parameter int DW      = 16,
  parameter int DEPTH   = 8,
  parameter int BAUDDIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  wb_uart_tx_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int NB = (DW + 7) / 8;
  localparam int SW = NB * 8;
  localparam int CW = $clog2(BAUDDIV);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [BW-1:0] byte_q, byte_d;
  logic          txd_q, txd_d;
  logic [SW-1:0] shreg_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic pop;
  logic push;
  logic shift;
  logic baud_end;

  assign baud_end = (baud_q == CW'(BAUDDIV - 1));

  // A same-edge pop frees a slot, so a full FIFO still accepts the word.
  assign push = rst && bus.we && ((level_q != LW'(DEPTH)) || pop);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (level_q != '0) begin
          pop     = 1'b1;
          state_d = START;
          byte_d  = '0;
          baud_d  = '0;
          bit_d   = '0;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          txd_d   = shreg_q[0];
          shift   = 1'b1;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = shreg_q[0];
            shift = 1'b1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (byte_q != BW'(NB - 1)) begin
            byte_d  = byte_q + BW'(1);
            state_d = START;
            txd_d   = 1'b0;
          end else if (level_q != '0) begin
            pop     = 1'b1;
            byte_d  = '0;
            state_d = START;
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_comb begin
    level_d = level_q + LW'(push) - LW'(pop);
    ovf_d   = ovf_q | (bus.we & ~push);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      txd_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      txd_q    <= txd_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_q + AW'(push);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
    end
  end

  // Storage has no reset; occupancy is tracked solely by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.rwd;
    end
  end

  // The head word is read straight into the shifter; upper pad bits stay 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg_q <= '0;
    end else if (pop) begin
      shreg_q <= SW'(mem_q[rd_ptr_q]);
    end else if (shift) begin
      shreg_q <= shreg_q >> 1;
    end
  end

  assign bus.txd   = txd_q;
  assign bus.busy  = (state_q != IDLE) || (level_q != '0);
  assign bus.ovf   = ovf_q;
  assign bus.level = level_q;
endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed bench for wb_uart_tx: a line receiver decodes txd into words and
// compares them against a queue of expected words filled as writes are driven.
module tb_wb_uart_tx;
  localparam int DW      = 16;
  localparam int DEPTH   = 8;
  localparam int BAUDDIV = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  wb_uart_tx_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  wb_uart_tx #(.DW(DW), .DEPTH(DEPTH), .BAUDDIV(BAUDDIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [DW-1:0] data;
    bit            b2b;
  } exp_t;

  exp_t sb[$];
  int   tests    = 0;
  int   fails    = 0;
  int   rx_words = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input logic [DW-1:0] d, input bit b2b);
    exp_t e;
    e.data = d;
    e.b2b  = b2b;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((bus.busy !== 1'b0 || sb.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  // Line receiver: samples one clock after each edge, mid-bit.
  initial begin
    int            cnt;
    int            cyc;
    int            last_end;
    bit            active;
    int            bidx;
    logic [7:0]    sh;
    logic [7:0]    lo;
    logic [DW-1:0] word;
    exp_t          e;
    cnt = 0; cyc = 0; last_end = -100; active = 0; bidx = 0; sh = '0; lo = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst !== 1'b1) begin
        active   = 0;
        bidx     = 0;
        last_end = -100;
      end else if (!active) begin
        if (bus.txd === 1'b0) begin
          active = 1;
          cnt    = 0;
          if (bidx == 1)
            check("byte_gap", 32'(cyc), 32'(last_end + 1));
          else if (sb.size() > 0 && sb[0].b2b)
            check("word_gap", 32'(cyc), 32'(last_end + 1));
        end
      end else begin
        cnt++;
        if (cnt == BAUDDIV / 2)
          check("start_bit", 32'(bus.txd), 32'd0);
        else if ((cnt % BAUDDIV) == BAUDDIV / 2 && cnt < 9 * BAUDDIV)
          sh[cnt / BAUDDIV - 1] = bus.txd;
        else if (cnt == 9 * BAUDDIV + BAUDDIV / 2)
          check("stop_bit", 32'(bus.txd), 32'd1);
        if (cnt == 10 * BAUDDIV - 1) begin
          active   = 0;
          last_end = cyc;
          if (bidx == 0) begin
            lo   = sh;
            bidx = 1;
          end else begin
            bidx = 0;
            rx_words++;
            word = {sh, lo};
            $display("[TB] rx word 0x%04h at cycle %0d", word, cyc);
            check("rx_expected_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() > 0) begin
              e = sb.pop_front();
              check("rx_word", 32'(word), 32'(e.data));
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b0;
    bus.we  = 1'b0;
    bus.rwd = '0;
    repeat (3) @(negedge clk);

    // Word presented on a reset edge must be dropped.
    bus.we  = 1'b1;
    bus.rwd = 16'hDEAD;
    @(negedge clk);
    bus.we = 1'b0;
    check("rst_txd", 32'(bus.txd), 32'd1);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_we_discarded", 32'(bus.level), 32'd0);

    // Single word, latency and busy fall.
    bus.we  = 1'b1;
    bus.rwd = 16'h1234;
    expect_word(16'h1234, 1'b0);
    $display("[TB] write 0x1234");
    @(negedge clk);
    bus.we = 1'b0;
    check("lat_level_k", 32'(bus.level), 32'd1);
    check("lat_txd_k", 32'(bus.txd), 32'd1);
    check("lat_busy_k", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("lat_txd_k1", 32'(bus.txd), 32'd0);
    check("lat_level_k1", 32'(bus.level), 32'd0);
    repeat (79) @(negedge clk);
    check("busy_last_stop", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("busy_fall", 32'(bus.busy), 32'd0);
    check("single_drained", 32'(sb.size()), 32'd0);

    // Two words back to back.
    bus.we  = 1'b1;
    bus.rwd = 16'hA5C3;
    expect_word(16'hA5C3, 1'b0);
    $display("[TB] write 0xA5C3");
    @(negedge clk);
    bus.rwd = 16'h0F01;
    expect_word(16'h0F01, 1'b1);
    $display("[TB] write 0x0F01");
    @(negedge clk);
    bus.we = 1'b0;
    wait_done("b2b_done", 1000);
    check("b2b_ovf_clear", 32'(bus.ovf), 32'd0);

    // Ten writes into depth 8: word 10 dropped.
    for (int i = 1; i <= 10; i++) begin
      bus.we  = 1'b1;
      bus.rwd = DW'(i);
      if (i <= 9) expect_word(DW'(i), i != 1);
      $display("[TB] write 0x%04h", i);
      @(negedge clk);
    end
    bus.we = 1'b0;
    check("ovf_level", 32'(bus.level), 32'd8);
    check("ovf_flag", 32'(bus.ovf), 32'd1);

    // Write on the exact edge word 2 is popped while full.
    repeat (71) @(negedge clk);
    check("full_before_pop", 32'(bus.level), 32'd8);
    bus.we  = 1'b1;
    bus.rwd = 16'h00BB;
    expect_word(16'h00BB, 1'b1);
    $display("[TB] write 0x00BB on pop edge");
    @(negedge clk);
    bus.we = 1'b0;
    check("full_pop_level", 32'(bus.level), 32'd8);
    check("full_pop_ovf", 32'(bus.ovf), 32'd1);
    wait_done("ovf_done", 3000);

    // Reset while byte 0 of a word is in its data bits.
    bus.we  = 1'b1;
    bus.rwd = 16'h5AF0;
    expect_word(16'h5AF0, 1'b0);
    @(negedge clk);
    bus.rwd = 16'h1111;
    expect_word(16'h1111, 1'b1);
    @(negedge clk);
    bus.we = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy", 32'(bus.busy), 32'd1);
    check("mid_level", 32'(bus.level), 32'd1);
    rst = 1'b0;
    sb.delete();
    $display("[TB] reset mid-frame");
    @(negedge clk);
    rst = 1'b1;
    check("midrst_txd", 32'(bus.txd), 32'd1);
    check("midrst_level", 32'(bus.level), 32'd0);
    check("midrst_ovf", 32'(bus.ovf), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    repeat (5) @(negedge clk);
    check("midrst_no_resume", 32'(bus.txd), 32'd1);

    bus.we  = 1'b1;
    bus.rwd = 16'hC0DE;
    expect_word(16'hC0DE, 1'b0);
    $display("[TB] write 0xC0DE");
    @(negedge clk);
    bus.we = 1'b0;
    wait_done("post_rst_done", 1000);

    repeat (5) @(negedge clk);
    check("rx_word_count", 32'(rx_words), 32'd14);
    check("final_idle_txd", 32'(bus.txd), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_uart_tx.md
WB_UART_TX -- requirements
Module: wb_uart_tx

Interface
REQ-001 Parameter DW, default 16, SHALL set the write-back data width; instantiate with `WIDTH+1 from pu.vh.
REQ-002 Parameter DEPTH, default 8, SHALL set the FIFO depth in words; power of two, 2 or more.
REQ-003 Parameter BAUDDIV, default 4, SHALL set the clocks per serial bit; 2 or more.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on the rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-low reset.
REQ-006 we  input  1  SHALL be the register-file write strobe from pu.
REQ-007 rwd  input  DW  SHALL be the register write-back data from pu; sampled only when we=1.
REQ-008 txd  output  1  SHALL be the serial line; idle high.
REQ-009 busy  output  1  SHALL be 1 whenever state is not IDLE or level>0.
REQ-010 ovf  output  1  SHALL be a sticky flag: at least one write-back word was dropped.
REQ-011 level  output  log2(DEPTH)+1  SHALL be the current FIFO occupancy.

Function
REQ-012 Each rising edge with we=1 SHALL push rwd into the FIFO if level<DEPTH after any same-edge pop is counted; otherwise the word SHALL be discarded and ovf set to 1.
REQ-013 A push and a pop on the same edge SHALL both succeed, including when level=DEPTH; level is then unchanged.
REQ-014 The FIFO SHALL be first-in, first-out; read and write pointers SHALL wrap modulo DEPTH.
REQ-015 The transmit FSM SHALL have exactly four states: IDLE, START, DATA, STOP.
REQ-016 From IDLE with level>0, the next edge SHALL pop the head word into the shift register, clear the byte index to 0, and enter START.
REQ-017 Each word SHALL be sent as NB=ceil(DW/8) bytes, least-significant byte first; pad bits above DW SHALL be 0.
REQ-018 Each byte SHALL be framed as 1 start bit (0), 8 data bits LSB first, then 1 stop bit (1).
REQ-019 Each bit SHALL hold txd for exactly BAUDDIV clocks, so one byte takes 10*BAUDDIV clocks.
REQ-020 txd SHALL be a registered output, high in IDLE and in STOP.
REQ-021 At the end of STOP with byte index<NB-1, the FSM SHALL increment the byte index and enter START with no idle gap.
REQ-022 At the end of STOP of the last byte with level>0, the FSM SHALL pop the next word and enter START directly (back-to-back).
REQ-023 At the end of STOP of the last byte with level=0, the FSM SHALL enter IDLE.
REQ-024 Latency: a word written at edge k into an empty FIFO while IDLE SHALL be popped at edge k+1, with txd=0 from edge k+1.
REQ-025 ovf SHALL clear only on reset; a new drop while ovf=1 SHALL leave it at 1.
REQ-026 The block SHALL never assert backpressure toward pu; a full FIFO drops words instead.

Reset
REQ-027 When rst=0 at an edge, the block SHALL set state=IDLE, txd=1, level=0, ovf=0, busy=0, pointers=0, and byte and bit counters=0.
REQ-028 Reset SHALL take priority over we; a word presented on the reset edge SHALL be discarded.
REQ-029 Reset mid-frame SHALL abort the frame immediately; txd=1 from that edge on and no partial byte resumes.

Verification
REQ-030 Single word: DW=16, BAUDDIV=4, one write of rwd=0x1234 -> txd frames 0x34 then 0x12 with no gap between them.
      - Line pattern per byte: 0, data LSB first, 1; 80 clocks total.
      - busy falls one edge after the last stop bit ends.
REQ-031 Latency: write at edge k while IDLE -> level=1 after edge k; txd=0 and level=0 after edge k+1.
REQ-032 Overflow: DEPTH=8, ten consecutive writes 1..10 -> word 1 is transmitting, words 2..9 are queued, word 10 is dropped.
      - Flags: level=8, ovf=1.
      - Output: transmitted order is 1..9.
REQ-033 Full plus pop: level=8 and we=1 on the edge a pop occurs -> word accepted, level stays 8, ovf unchanged.
REQ-034 Back-to-back words: two words queued -> second word's start bit immediately follows the first word's final stop bit.
REQ-035 Reset mid-frame: rst=0 during DATA of byte 0 -> next edge txd=1, level=0, ovf=0, busy=0.
      - Follow-up: a later write transmits normally.
